// File: rtl/sysid_regs.sv
// sysid_regs
// System-identification and uptime register bank on an Avalon-MM slave.
// Word map: 0 SYSID (RO), 1 TIMESTAMP (RO), 2 SCRATCH (RW), 3 UPTIME_LO (RO),
// 4 UPTIME_HI shadow (RO), 5 CTRL {OVF,CLR,EN}, 6 TICK_DIV (RW), 7 reserved.
//
// Ports:
//   clock         sole clock
//   reset         synchronous, active-high reset
//   address[2:0]  word address
//   read          read strobe
//   write         write strobe
//   writedata     write data
//   byteenable    write byte lanes
//   readdata      registered read data, holds when readdatavalid is low
//   readdatavalid one-cycle pulse qualifying readdata
//
// UPTIME_WIDTH is meant to lie in 33..64 so that the HI shadow is 1..32 bits.

module sysid_regs #(
   parameter logic [31:0] SYSID_VALUE     = 32'h0000_0391,
   parameter logic [31:0] TIMESTAMP_VALUE = 32'h0000_0000,
   parameter int          UPTIME_WIDTH    = 48,
   parameter logic [31:0] TICK_DIV_RESET  = 32'd49
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        readdatavalid
);

   localparam int HI_WIDTH = UPTIME_WIDTH - 32;

   localparam logic [2:0] ADDR_SYSID     = 3'd0;
   localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
   localparam logic [2:0] ADDR_SCRATCH   = 3'd2;
   localparam logic [2:0] ADDR_UPTIME_LO = 3'd3;
   localparam logic [2:0] ADDR_UPTIME_HI = 3'd4;
   localparam logic [2:0] ADDR_CTRL      = 3'd5;
   localparam logic [2:0] ADDR_TICK_DIV  = 3'd6;

   logic [31:0]             scratch;
   logic [31:0]             tick_div;
   logic [31:0]             presc;
   logic [UPTIME_WIDTH-1:0] count;
   logic [HI_WIDTH-1:0]     shadow_hi;
   logic                    en;
   logic                    ovf;

   logic                    rd_pending;
   logic [31:0]             rd_data_q;

   logic                    wr_scratch;
   logic                    wr_ctrl;
   logic                    wr_tick_div;
   logic                    ctrl_clr;
   logic                    ovf_w1c;
   logic                    tick;
   logic                    wrap;
   logic                    rd_lo;
   logic [31:0]             hi_ext;
   logic [31:0]             rd_mux;

   // Bus decode, tick/wrap detection and the read multiplexer. Everything
   // here looks at pre-edge state, so a read in the same cycle as a write
   // returns the old value. CTRL bits only exist in byte lane 0. A CLR in
   // the same cycle as a wrap suppresses the overflow flag, because the
   // count is zeroed instead of wrapping.
   always_comb begin
      wr_scratch  = write && (address == ADDR_SCRATCH);
      wr_ctrl     = write && (address == ADDR_CTRL) && byteenable[0];
      wr_tick_div = write && (address == ADDR_TICK_DIV);
      ctrl_clr    = wr_ctrl && writedata[1];
      ovf_w1c     = wr_ctrl && writedata[2];
      tick        = en && (presc == tick_div);
      wrap        = tick && (count == '1) && !ctrl_clr;
      rd_lo       = read && (address == ADDR_UPTIME_LO);

      hi_ext                = '0;
      hi_ext[HI_WIDTH-1:0]  = shadow_hi;

      rd_mux = '0;
      case (address)
         ADDR_SYSID:     rd_mux = SYSID_VALUE;
         ADDR_TIMESTAMP: rd_mux = TIMESTAMP_VALUE;
         ADDR_SCRATCH:   rd_mux = scratch;
         ADDR_UPTIME_LO: rd_mux = count[31:0];
         ADDR_UPTIME_HI: rd_mux = hi_ext;
         ADDR_CTRL:      rd_mux = {29'd0, ovf, 1'b0, en};
         ADDR_TICK_DIV:  rd_mux = tick_div;
         default:        rd_mux = '0;
      endcase
   end

   // Prescaler and uptime counter. CLR has top priority and zeroes both,
   // even on a tick edge. Otherwise a tick advances the count, and either a
   // tick or any TICK_DIV write restarts the prescaler; with EN low nothing
   // moves.
   always_ff @(posedge clock) begin
      if (reset) begin
         presc <= '0;
         count <= '0;
      end else if (ctrl_clr) begin
         presc <= '0;
         count <= '0;
      end else begin
         if (tick) begin
            count <= count + UPTIME_WIDTH'(1);
         end
         if (wr_tick_div || tick) begin
            presc <= '0;
         end else if (en) begin
            presc <= presc + 32'd1;
         end
      end
   end

   // CTRL flags. A wrap that coincides with a write-1-to-clear of OVF must
   // leave OVF set, so the set path is checked first.
   always_ff @(posedge clock) begin
      if (reset) begin
         en  <= 1'b1;
         ovf <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en <= writedata[0];
         end
         if (wrap) begin
            ovf <= 1'b1;
         end else if (ovf_w1c) begin
            ovf <= 1'b0;
         end
      end
   end

   // Byte-lane writable registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         scratch  <= '0;
         tick_div <= TICK_DIV_RESET;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (byteenable[i]) begin
               if (wr_scratch) begin
                  scratch[8*i +: 8] <= writedata[8*i +: 8];
               end
               if (wr_tick_div) begin
                  tick_div[8*i +: 8] <= writedata[8*i +: 8];
               end
            end
         end
      end
   end

   // Two-stage read pipeline. The first stage captures the selected word
   // (and, for UPTIME_LO, the upper count bits into the HI shadow) from the
   // same pre-edge count, so LO/HI form an atomic pair. The second stage
   // presents it on the bus; a reset between the stages drops the pending
   // response.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_pending    <= 1'b0;
         rd_data_q     <= '0;
         shadow_hi     <= '0;
         readdata      <= '0;
         readdatavalid <= 1'b0;
      end else begin
         rd_pending <= read;
         if (read) begin
            rd_data_q <= rd_mux;
         end
         if (rd_lo) begin
            shadow_hi <= count[UPTIME_WIDTH-1:32];
         end
         readdatavalid <= rd_pending;
         if (rd_pending) begin
            readdata <= rd_data_q;
         end
      end
   end

endmodule

// File: doc/sysid_regs.md
# sysid_regs

Parametrised system-identification and uptime register bank on the Avalon-MM bus, successor to the fixed two-word SysID slave. Software gets:

- read-only ID and build-timestamp words;
- a scratch register for bus sanity checks;
- a prescaled free-running uptime counter with atomic 64-bit readout;
- a control/status word.

Reads use a fixed one-cycle latency with `readdatavalid`, so the block sits behind the HPS lightweight bridge alongside the other peripherals.

## Interface
Parameters:
- `SYSID_VALUE`, 32'h0000_0391, constant returned at word 0
- `TIMESTAMP_VALUE`, 32'h0000_0000, build timestamp returned at word 1
- `UPTIME_WIDTH`, 48, uptime counter width, legal range 33..64
- `TICK_DIV_RESET`, 32'd49, reset value of the prescaler reload; one tick every TICK_DIV+1 clocks

Ports:
- `clock`  in  1  sole clock
- `reset`  in  1  synchronous, active-high reset
- `address`  in  3  word address
- `read`  in  1  read strobe
- `write`  in  1  write strobe
- `writedata`  in  32  write data
- `byteenable`  in  4  write byte lanes
- `readdata`  out  32  registered read data
- `readdatavalid`  out  1  one-cycle pulse qualifying `readdata`

## Operation
Register map (word addresses):
- 0 SYSID: read-only, `SYSID_VALUE`.
- 1 TIMESTAMP: read-only, `TIMESTAMP_VALUE`.
- 2 SCRATCH: read/write, honours `byteenable`, reset 0.
- 3 UPTIME_LO: read-only, count[31:0].
  - A read also copies count[UPTIME_WIDTH-1:32] into the HI shadow in the same cycle.
- 4 UPTIME_HI: read-only, shadow register, zero-extended to 32 bits, reset 0.
- 5 CTRL: all other bits read 0.
  - bit0 EN: read/write, reset 1.
  - bit1 CLR: write-1 pulse, self-clearing, reads 0.
  - bit2 OVF: sticky, write-1-to-clear, reset 0.
- 6 TICK_DIV: read/write, honours `byteenable`, reset `TICK_DIV_RESET`.
- 7 reserved: reads 0, writes ignored.

Prescaler:
- `presc` counts 0..TICK_DIV while EN=1 and holds while EN=0.
- When `presc`==TICK_DIV, it returns to 0 and the uptime count increments.
- Any write to TICK_DIV forces `presc` to 0.
- TICK_DIV=0 gives one tick per clock.

Uptime count:
- It is `UPTIME_WIDTH` bits.
- All-ones + tick wraps to 0 and sets OVF.

Priority rules:
- CLR vs tick in the same cycle: the count and `presc` are zeroed, and OVF is unaffected.
- OVF set vs W1C in the same cycle: the set wins, and OVF=1.
- `read` and `write` in the same cycle are both processed. `readdata` reflects state before the write.
- Writes to read-only words are ignored.
- Read-only words ignore `byteenable`.
- SCRATCH and TICK_DIV are updated per byte lane. CTRL bits live in lane 0 only.

## Timing
Reset, while `reset`=1 at a clock edge:
- `readdata`=0, `readdatavalid`=0;
- count=0, `presc`=0, shadow=0, SCRATCH=0, EN=1, OVF=0, TICK_DIV=`TICK_DIV_RESET`.

Reset mid-read: the pending `readdatavalid` is suppressed.

Read latency:
- `read` sampled at edge N gives `readdata` and `readdatavalid`=1 after edge N+1, for exactly one cycle.
- `readdata` holds its last value when `readdatavalid`=0.
- Back-to-back reads give back-to-back valid pulses.

Write latency:
- A write sampled at edge N takes effect after edge N.
- A read sampled at N+1 sees the new value.

UPTIME_LO/HI atomicity:
- The LO value returned and the shadow capture come from the same pre-edge count.
- Any number of cycles may elapse before the HI read.

EN=0: the count and `presc` freeze immediately at the next edge.

No wait states: `waitrequest` is not implemented.

## Test plan
- **Reset and ID readback:** after reset, read 0, 1, 2, 5, 6, 7.
  - Required: SYSID_VALUE, TIMESTAMP_VALUE, 0, 32'h1, 49, 0.
  - Each `readdatavalid` arrives exactly 1 cycle after `read`.
- **Scratch byte lanes:** write 32'hDEADBEEF with `byteenable`=4'b1111, then write 32'h0000_0012 with `byteenable`=4'b0001.
  - Required: read 2 returns 32'hDEADBE12.
- **Prescaler:**
  - TICK_DIV=3, CLR=1, then wait 40 clocks: UPTIME_LO reads 10 (±1 per the read-edge phase, exact value checked against the model).
  - Then TICK_DIV=0 for 5 clocks: the count advances by 5.
- **Atomic readout across a 32-bit carry:** force the count to 32'hFFFF_FFFF with TICK_DIV=0.
  - Reading LO returns FFFF_FFFF (or the next value), with HI consistent with it.
  - A HI read 10 cycles later still matches the latched upper bits.
- **Overflow:** UPTIME_WIDTH=33, count near all-ones.
  - On wrap: the count goes to 0, OVF=1, and OVF stays set.
  - Writing CTRL=32'h5 clears OVF and keeps EN.
  - A W1C write landing on a wrap edge leaves OVF=1.
- **Freeze and clear:**
  - EN=0 holds the count constant over 100 clocks.
  - CLR on the same edge as a tick gives count=0, `presc`=0.
  - Reset asserted the cycle after a read gives no `readdatavalid`.
